fifo_rd_streamer: RTL and testbench

- Read-side master for the synchronous FIFO: drains words through the FIFO's rd_en/empty/dout port.
- Re-presents those words on a valid/ready stream toward a downstream consumer.
- Absorbs the FIFO's 1-cycle read latency in a 2-entry skid buffer, so throughput is 1 word/clock under continuous m_ready.
- Never issues a read when the FIFO is empty.

---
 rtl/fifo_rd_streamer.sv | 64 ++++++
 tb/tb_fifo_rd_streamer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: drains a sync FIFO into a valid/ready stream via a 2-entry skid buffer; FIFO_RD_STATS_EN adds xfer_count
module fifo_rd_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  xfer_count
`endif
);
  logic [1:0] occ_q, occ_d;
  logic [2:0] need;
  logic inflight_q, inflight_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, pop;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  assign m_valid = occ_q != 2'd0;
  assign m_data  = buf_q[rd_ptr_q];
  assign busy    = inflight_q || m_valid;
  always_comb begin
    pop = m_valid && m_ready;
    need = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    fifo_rd_en = !rst && enable && !fifo_empty && (need < 3'd2);
    occ_d = need[1:0];
    inflight_d = fifo_rd_en;
    wr_ptr_d = wr_ptr_q ^ inflight_q;
    rd_ptr_d = rd_ptr_q ^ pop;
    buf_d = buf_q;
    if (inflight_q) buf_d[wr_ptr_q] = fifo_dout;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      buf_q      <= '{default: '0};
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      buf_q      <= buf_d;
    end
  end
`ifdef FIFO_RD_STATS_EN
  logic [CNT_WIDTH-1:0] xfer_q, xfer_d;
  assign xfer_count = xfer_q;
  always_comb xfer_d = pop ? xfer_q + CNT_WIDTH'(1) : xfer_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) xfer_q <= '0;
    else xfer_q <= xfer_d;
  end
`endif
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: queue-based model of the streamer plus directed scenarios with literal expectations
module tb_fifo_rd_streamer;
  logic clk = 1'b0, rst, enable, m_ready;
  logic fifo_empty, fifo_rd_en, m_valid, busy;
  logic [7:0] fifo_dout, m_data;
`ifdef FIFO_RD_STATS_EN
  logic [3:0] xfer_count;
`endif
  int checks = 0, errors = 0;
  logic [7:0] mem [128];
  int head = 0, tail = 0, cyc = 0, rd_pulses = 0;
  logic [7:0] dout_r = 8'h00;
  logic [7:0] mq [$];
  logic [7:0] popped [$];
  int pop_cyc [$];
  logic mi = 1'b0, e_rd = 1'b0, e_pop = 1'b0;
  logic [3:0] xc = 4'd0;

  assign fifo_empty = head == tail;
  assign fifo_dout  = dout_r;
  always #5 clk = ~clk;

  fifo_rd_streamer #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .busy(busy)
`ifdef FIFO_RD_STATS_EN
    , .xfer_count(xfer_count)
`endif
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(logic [7:0] first, int n);
    for (int i = 0; i < n; i++) begin
      mem[tail] = first + 8'(i);
      tail++;
    end
  endtask

  // FIFO emulation and model state advance: words land two edges after their read strobe
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mi <= 1'b0;
      xc <= 4'd0;
    end else begin
      cyc <= cyc + 1;
      if (e_pop) begin
        popped.push_back(mq.pop_front());
        pop_cyc.push_back(cyc);
        xc <= xc + 4'd1;
      end
      if (mi) mq.push_back(dout_r);
      mi <= e_rd;
      if (fifo_rd_en) begin
        dout_r <= mem[head];
        head <= head + 1;
        rd_pulses <= rd_pulses + 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int n;
    logic ep, er;
    n = mq.size();
    ep = (n != 0) && m_ready;
    er = !rst && enable && !fifo_empty && (n + int'(mi) - int'(ep) < 2);
    e_pop <= ep;
    e_rd <= er;
    if (!rst) begin
      chk("m_valid", 32'(m_valid), 32'(n != 0));
      if (n != 0) chk("m_data", 32'(m_data), 32'(mq[0]));
      chk("busy", 32'(busy), 32'(mi || n != 0));
      chk("fifo_rd_en", 32'(fifo_rd_en), 32'(er));
`ifdef FIFO_RD_STATS_EN
      chk("xfer_count", 32'(xfer_count), 32'(xc));
`endif
    end
  end

  initial begin
    int rb, pb;
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
    #1;
    chk("rst m_valid", 32'(m_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst rd_en", 32'(fifo_rd_en), 0);
    chk("rst m_data", 32'(m_data), 0);
    step(2);
    rst = 1'b0;
    step(1);
    // basic latency
    rb = rd_pulses;
    enable = 1'b1; m_ready = 1'b1;
    load(8'hA5, 1);
    #1 chk("lat rd_en", 32'(fifo_rd_en), 1);
    step(1);
    chk("lat rd_en off", 32'(fifo_rd_en), 0);
    chk("lat valid T+1", 32'(m_valid), 0);
    chk("lat busy T+1", 32'(busy), 1);
    step(1);
    chk("lat valid T+2", 32'(m_valid), 1);
    chk("lat data T+2", 32'(m_data), 32'hA5);
    step(1);
    chk("lat valid end", 32'(m_valid), 0);
    chk("lat busy end", 32'(busy), 0);
    chk("lat pulses", 32'(rd_pulses - rb), 1);
    // streaming, no bubbles
    pb = popped.size();
    load(8'h01, 8);
    step(12);
    chk("stream count", 32'(popped.size() - pb), 8);
    for (int i = 0; i < 8; i++) chk("stream word", 32'(popped[pb + i]), 32'(i + 1));
    chk("stream span", 32'(pop_cyc[pb + 7] - pop_cyc[pb]), 7);
    // backpressure
    m_ready = 1'b0;
    rb = rd_pulses; pb = popped.size();
    load(8'h11, 4);
    step(6);
    chk("bp pulses", 32'(rd_pulses - rb), 2);
    chk("bp valid", 32'(m_valid), 1);
    chk("bp data", 32'(m_data), 32'h11);
    m_ready = 1'b1;
    step(8);
    chk("bp count", 32'(popped.size() - pb), 4);
    for (int i = 0; i < 4; i++) chk("bp word", 32'(popped[pb + i]), 32'(8'h11 + i));
    // enable drop mid-stream
    pb = popped.size(); rb = rd_pulses;
    load(8'h20, 10);
    step(5);
    enable = 1'b0;
    #1 chk("drop rd_en", 32'(fifo_rd_en), 0);
    step(5);
    chk("drop busy", 32'(busy), 0);
    chk("drop no loss", 32'(popped.size() - pb), 32'(rd_pulses - rb));
    enable = 1'b1;
    step(10);
    chk("drain empty", 32'(fifo_empty), 1);
    // async reset mid-stream
    load(8'h40, 6);
    step(3);
    #2 rst = 1'b1;
    #1;
    chk("arst m_valid", 32'(m_valid), 0);
    chk("arst busy", 32'(busy), 0);
    chk("arst rd_en", 32'(fifo_rd_en), 0);
    step(1);
    rst = 1'b0;
    pb = popped.size();
    step(8);
    chk("arst count", 32'(popped.size() - pb), 3);
    for (int i = 0; i < 3; i++) chk("arst word", 32'(popped[pb + i]), 32'(8'h43 + i));
    // 17 words: counter wraps to 1, frozen while stalled
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    m_ready = 1'b0;
    pb = popped.size();
    load(8'h60, 17);
    step(4);
    chk("stall valid", 32'(m_valid), 1);
`ifdef FIFO_RD_STATS_EN
    chk("stats stall", 32'(xfer_count), 0);
`endif
    m_ready = 1'b1;
    step(25);
    chk("stats words", 32'(popped.size() - pb), 17);
`ifdef FIFO_RD_STATS_EN
    chk("stats wrap", 32'(xfer_count), 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
